// File: rtl/lfsr_capture_controller.sv
// Purpose : turns a raw pushbutton (plus optional periodic auto-capture) into
//           single-cycle write-enable pulses for the LFSR display register.
// Latency : press -> o_we high in the cycle after edge k+SYNC_STAGES+DEBOUNCE_CYCLES.
// Backpressure: none; i_freeze blocks new captures (a committed CAPTURE still fires).
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   i_btn_write       raw pushbutton, asynchronous to clk
//   i_auto_en         enable periodic auto-capture
//   i_freeze          block new captures and clear the auto period counter
//   o_we              one-cycle write enable to the PIPO register
//   o_busy            FSM not idle
//   o_state           FSM state (debug)
//   o_capture_count   number of o_we pulses issued, wraps
module lfsr_capture_controller #(
    parameter int SYNC_STAGES        = 2,
    parameter int DEBOUNCE_CYCLES    = 4,
    parameter int AUTO_PERIOD_CYCLES = 8,
    parameter int COUNT_WIDTH        = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_btn_write,
    input  logic                   i_auto_en,
    input  logic                   i_freeze,
    output logic                   o_we,
    output logic                   o_busy,
    output logic [1:0]             o_state,
    output logic [COUNT_WIDTH-1:0] o_capture_count
);

    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PER_W = (AUTO_PERIOD_CYCLES > 1) ? $clog2(AUTO_PERIOD_CYCLES) : 1;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(AUTO_PERIOD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        DEBOUNCE = 2'b01,
        CAPTURE  = 2'b10,
        RELEASE  = 2'b11
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DB_W-1:0]        db_cnt;
    logic [PER_W-1:0]       per_cnt;
    logic                   btn_s;
    logic                   auto_fire;
    logic                   capture_go;

    // Button synchronizer: shift in at bit 0, use the oldest stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_btn_write};
        end
    end

    assign btn_s = sync_q[SYNC_STAGES-1];

    // Auto pulses can only start from IDLE, so they never abut a button pulse.
    assign auto_fire  = (state == IDLE) && i_auto_en && !i_freeze && (per_cnt == PER_LAST);

    // Last debounce cycle with the button still held: next state is CAPTURE.
    assign capture_go = (state == DEBOUNCE) && btn_s && !i_freeze && (db_cnt == DB_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            db_cnt          <= '0;
            per_cnt         <= '0;
            o_we            <= 1'b0;
            o_capture_count <= '0;
        end else begin
            // o_we is registered alongside the state so it is high exactly
            // while state==CAPTURE, or for the cycle after an auto terminal count.
            o_we            <= capture_go | auto_fire;
            o_capture_count <= o_capture_count + COUNT_WIDTH'(capture_go | auto_fire);

            // Period counter holds (not clears) while a button capture is in flight.
            if (!i_auto_en || i_freeze) begin
                per_cnt <= '0;
            end else if (state == IDLE) begin
                per_cnt <= (per_cnt == PER_LAST) ? '0 : per_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (btn_s && !i_freeze) begin
                        state  <= DEBOUNCE;
                        db_cnt <= '0;
                    end
                end
                DEBOUNCE: begin
                    if (!btn_s || i_freeze) begin
                        state <= IDLE;
                    end else if (db_cnt == DB_LAST) begin
                        state <= CAPTURE;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    state  <= RELEASE;
                    db_cnt <= '0;
                end
                RELEASE: begin
                    // Any bounce back to 1 restarts the release window.
                    if (btn_s) begin
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state <= IDLE;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_busy  = (state != IDLE);
    assign o_state = state;

endmodule
